// File: rtl/imem_pkg.sv
// Shared types and default sizes for the loadable instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Burst loader: walks a write pointer from a base address for a clamped word count.
// Latency: a word is written in the cycle it is accepted; done pulses the cycle after the last accept.
// Backpressure: ld_ready_o is high only while loading; the source holds its word until ready.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  // Memory depth as a length value; longer bursts are cut to this.
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_clamped;

  assign len_clamped = (ld_len_i > DEPTH_LEN) ? DEPTH_LEN : ld_len_i;

  // State, pointer and remaining-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; the pointer wraps naturally at ADDR_W bits.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ld_ready_o = 1'b0;
    ld_done_o  = 1'b0;
    wr_en_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          ptr_d   = ld_base_i;
          cnt_d   = len_clamped;
          state_d = (len_clamped != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          wr_en_o = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q - (ADDR_W+1)'(1);
          if (cnt_q == (ADDR_W+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ld_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_busy_o = (state_q != IDLE);
  assign wr_addr_o = ptr_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a registered fetch port and a burst loader write port; IMEM_PARITY_EN adds per-word even parity.
// Latency: fetch data and rd_valid one cycle after rd_en; reads are read-first against a same-cycle load write.
// Backpressure: fetches are never stalled; the load source is throttled by ld_ready.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;

  imem_loader #(
    .ADDR_W(ADDR_W)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start_i (ld_start),
    .ld_base_i  (ld_base),
    .ld_len_i   (ld_len),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .ld_busy_o  (ld_busy),
    .ld_done_o  (ld_done),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr)
  );

`ifdef IMEM_PARITY_EN
  // Stored bit makes the total count of ones in the word even.
  assign wr_word = {^ld_data, ld_data};
`else
  assign wr_word = ld_data;
`endif

  // Storage array; deliberately not reset so loaded code survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  assign rd_word   = mem_q[rd_addr];
  assign rd_data_d = rd_en ? rd_word[DATA_W-1:0] : rd_data_q;

  // Fetch register: samples the pre-write array contents, holds data on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef IMEM_PARITY_EN
  logic parity_err_q, parity_err_d;

  // A correctly stored word XORs to zero over data plus parity.
  assign parity_err_d = rd_en ? (^rd_word) : parity_err_q;

  // Parity flag tracks rd_data: updated on fetch, held on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts one-cycle fetch latency and done one cycle after the last accept.
// Backpressure: words are offered only while the model expects ld_ready.
module tb_imem_loadable;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
`ifdef IMEM_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  imem_loadable #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain array of words plus burst bookkeeping.
  logic [DW-1:0] m_mem    [DEPTH];
  bit            m_known  [DEPTH];
  bit            m_badpar [DEPTH];
  int            m_ptr;
  int            m_rem;
  bit            m_loading;
  bit            m_done;
  logic [DW-1:0] e_rd_data;
  bit            e_rd_known;
  bit            e_rd_valid;
  bit            e_par;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check loader status, predict the edge, advance, check fetch outputs.
  task automatic cycle();
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, m_loading});
    chk("ld_busy",  {63'd0, ld_busy},  {63'd0, (m_loading || m_done)});
    chk("ld_done",  {63'd0, ld_done},  {63'd0, m_done});
    // Read sees the array before this cycle's write.
    if (rd_en) begin
      e_rd_valid = 1'b1;
      e_rd_data  = m_mem[rd_addr];
      e_rd_known = m_known[rd_addr];
      e_par      = m_badpar[rd_addr];
    end else begin
      e_rd_valid = 1'b0;
    end
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_ptr]    = ld_data;
        m_known[m_ptr]  = 1'b1;
        m_badpar[m_ptr] = 1'b0;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (ld_start) begin
      m_ptr = int'(ld_base);
      m_rem = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
      if (m_rem > 0) m_loading = 1'b1;
      else           m_done    = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, e_rd_valid});
    if (e_rd_known) chk("rd_data", {32'd0, rd_data}, {32'd0, e_rd_data});
`ifdef IMEM_PARITY_EN
    if (e_rd_known) chk("parity_err", {63'd0, parity_err}, {63'd0, e_par});
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_rd_data",  {32'd0, rd_data},  64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_ld_busy",  {63'd0, ld_busy},  64'd0);
    chk("rst_ld_done",  {63'd0, ld_done},  64'd0);
`ifdef IMEM_PARITY_EN
    chk("rst_parity_err", {63'd0, parity_err}, 64'd0);
`endif
    m_loading  = 1'b0;
    m_done     = 1'b0;
    e_rd_data  = '0;
    e_rd_known = 1'b1;
    e_rd_valid = 1'b0;
    e_par      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_rd(input bit en);
    if (en) begin
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
    end else begin
      rd_en = 1'b0;
    end
  endtask

  // Whole burst: start, words (optionally with gaps and noise), done, back to idle.
  task automatic load_burst(input int base, input int len, input bit noisy);
    int words;
    words    = (len > DEPTH) ? DEPTH : len;
    ld_base  = AW'(base);
    ld_len   = (AW+1)'(len);
    ld_start = 1'b1;
    rand_rd(noisy);
    cycle();
    ld_start = 1'b0;
    for (int i = 0; i < words; i++) begin
      if (noisy) begin
        while ($urandom_range(0, 3) == 0) begin
          ld_valid = 1'b0;
          ld_start = ($urandom_range(0, 3) == 0);
          ld_base  = AW'($urandom);
          ld_len   = (AW+1)'($urandom_range(0, 20));
          rand_rd(1'b1);
          cycle();
        end
      end
      ld_valid = 1'b1;
      ld_data  = $urandom;
      rand_rd(noisy);
      cycle();
    end
    ld_valid = 1'b0;
    ld_start = noisy ? ($urandom_range(0, 1) == 1) : 1'b0;
    rand_rd(noisy);
    cycle();
    ld_start = 1'b0;
    rand_rd(noisy);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic fetch(input int addr);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    cycle();
    rd_en   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]    = '0;
      m_known[i]  = 1'b0;
      m_badpar[i] = 1'b0;
    end
    m_ptr = 0;
    m_rem = 0;
    do_reset();
    cycle();

    // Three-word burst at base 0 on back-to-back cycles, then fetch it back.
    ld_base = '0; ld_len = 10'd3; ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h0000_0202; cycle();
    ld_data  = 32'h0000_0203; cycle();
    ld_data  = 32'h0000_0498; cycle();
    ld_valid = 1'b0;
    chk("done_after_third", {63'd0, ld_done}, 64'd1);
    cycle();
    chk("done_one_cycle", {63'd0, ld_done}, 64'd0);
    for (int a = 0; a < 3; a++) fetch(a);
    cycle();

    // Fill 3..15 so later scenarios read known contents.
    load_burst(3, 13, 1'b0);

    // Burst that wraps from the top of the array to address 0.
    load_burst(510, 4, 1'b0);
    fetch(510); fetch(511); fetch(0); fetch(1);

    // Zero-length burst: one DONE cycle, no writes despite offered data.
    ld_base = AW'(3); ld_len = '0; ld_start = 1'b1;
    ld_valid = 1'b1; ld_data = 32'hDEAD_DEAD;
    cycle();
    ld_start = 1'b0;
    chk("len0_busy", {63'd0, ld_busy}, 64'd1);
    cycle();
    chk("len0_busy_clear", {63'd0, ld_busy}, 64'd0);
    ld_valid = 1'b0;
    cycle();
    fetch(3);

    // Same-cycle fetch and write of address 5: old word first, new word next.
    ld_base = AW'(5); ld_len = 10'd1; ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    rd_en = 1'b1; rd_addr = AW'(5);
    cycle();
    ld_valid = 1'b0;
    cycle();
    chk("rd5_new", {32'd0, rd_data}, {32'd0, 32'hDEAD_BEEF});
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_hold", {32'd0, rd_data}, {32'd0, 32'hDEAD_BEEF});
    end

    // Random bursts with gaps, ignored starts and concurrent fetches.
    for (int b = 0; b < 5; b++) begin
      load_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1'b1);
    end

    // Oversized length is cut to the array depth.
    load_burst($urandom_range(0, DEPTH - 1), 600, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rand_rd(1'b1);
      cycle();
    end
    rd_en = 1'b0;

    // Reset after two of four words: burst abandoned, written words kept.
    ld_base = '0; ld_len = 10'd4; ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = $urandom; cycle();
    ld_data = $urandom; cycle();
    do_reset();
    chk("post_rst_ready", {63'd0, ld_ready}, 64'd0);
    for (int i = 0; i < 3; i++) cycle();
    ld_valid = 1'b0;
    fetch(0); fetch(1); fetch(2);
    cycle();

`ifdef IMEM_PARITY_EN
    // Corrupt the stored parity bit of address 7 and fetch it.
    dut.mem_q[7][DW] = ~dut.mem_q[7][DW];
    m_badpar[7] = 1'b1;
    fetch(7);
    chk("parity_flag_7", {63'd0, parity_err}, 64'd1);
    fetch(8);
    cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning address width; depth is 2**ADDR_W words (512 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rd_en, input, 1 bit: fetch request.
REQ-006 The block SHALL have port rd_addr, input, ADDR_W bits: fetch address.
REQ-007 The block SHALL have port rd_data, output, DATA_W bits: registered instruction word.
REQ-008 The block SHALL have port rd_valid, output, 1 bit: rd_data holds the word for the previous accepted fetch.
REQ-009 The block SHALL have port ld_start, input, 1 bit: begin a load burst.
REQ-010 The block SHALL have port ld_base, input, ADDR_W bits: first load address, sampled with ld_start.
REQ-011 The block SHALL have port ld_len, input, ADDR_W+1 bits: burst length in words, sampled with ld_start.
REQ-012 The block SHALL have port ld_valid, input, 1 bit: ld_data is valid.
REQ-013 The block SHALL have port ld_data, input, DATA_W bits: word to write.
REQ-014 The block SHALL have port ld_ready, output, 1 bit: loader accepts a word this cycle.
REQ-015 The block SHALL have port ld_busy, output, 1 bit: loader not IDLE.
REQ-016 The block SHALL have port ld_done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-017 A fetch with rd_en=1 SHALL present mem[rd_addr] on rd_data after one clock and set rd_valid=1 in that cycle.
REQ-018 With rd_en=0, rd_data SHALL hold its previous value (stall) and rd_valid SHALL be 0.
REQ-019 The loader FSM SHALL have states IDLE, LOAD, DONE.
REQ-020 In IDLE, ld_start=1 SHALL latch ld_base into a write pointer and ld_len into a remaining-word counter.
REQ-021 On ld_start in IDLE, the FSM SHALL enter LOAD if ld_len>0, otherwise DONE.
REQ-022 ld_ready SHALL be 1 only in LOAD.
REQ-023 Each cycle with ld_valid and ld_ready both 1 SHALL write ld_data to mem[pointer], increment the pointer modulo 2**ADDR_W (wrap from max to 0), and decrement the counter.
REQ-024 The accept that decrements the counter to 0 SHALL move the FSM to DONE.
REQ-025 DONE SHALL last exactly one cycle, assert ld_done, then return to IDLE.
REQ-026 ld_start outside IDLE SHALL be ignored.
REQ-027 ld_len greater than the memory depth SHALL be clamped to the depth.
REQ-028 A simultaneous read and write to the same address SHALL return the old contents (read-first); the new word SHALL be visible on the next fetch.
REQ-029 Fetches SHALL remain serviced during LOAD; the block SHALL never stall reads for the loader.

Reset
REQ-030 While rst_n=0, rd_data SHALL be 0, rd_valid 0, ld_ready 0, ld_busy 0, ld_done 0, the FSM IDLE, and the pointer and counter 0.
REQ-031 Memory array contents SHALL NOT be cleared by reset; words written before a mid-burst reset SHALL be retained, and the burst SHALL be aborted without asserting ld_done.

Configuration
REQ-032 With IMEM_PARITY_EN defined, each word SHALL store one extra even-parity bit computed on write, and output port parity_err (1 bit) SHALL be registered alongside rd_data, asserting when the stored parity mismatches the read word; it SHALL be 0 at reset and hold during stalls.
REQ-033 Without IMEM_PARITY_EN, the parity storage and the parity_err port SHALL be absent, and storage width SHALL be DATA_W.

Structure
REQ-034 Package imem_pkg SHALL hold the loader state enum (IDLE/LOAD/DONE) and the default DATA_W/ADDR_W constants.
REQ-035 The loader FSM, pointer and counter SHALL be a sub-module named imem_loader; the storage array and read register SHALL stay in the top level.

Verification
REQ-036 The bench SHALL cover: reset, then ld_start with base=0, len=3, data 0x00000202/0x00000203/0x00000498 on consecutive cycles -> ld_done pulses one cycle after the third accept; fetches at 0,1,2 return those words at 1-cycle latency.
REQ-037 The bench SHALL cover: base=510, len=4 at ADDR_W=9 -> words land at 510, 511, 0, 1.
REQ-038 The bench SHALL cover: ld_len=0 -> ld_busy high for exactly one cycle, ld_done pulse, and no writes.
REQ-039 The bench SHALL cover: a fetch of addr 5 in the same cycle as a write of 0xDEADBEEF to addr 5 -> the old word is returned; the next fetch returns 0xDEADBEEF; rd_en=0 for 3 cycles -> rd_data held and rd_valid 0.
REQ-040 The bench SHALL cover: rst_n low after 2 of 4 words -> FSM IDLE and ld_ready 0, no ld_done, and words 0 and 1 retained.
REQ-041 The bench SHALL cover, with IMEM_PARITY_EN: force a stored parity bit flip at addr 7 -> a fetch of 7 asserts parity_err in the rd_valid cycle.
